// File: rtl/irrigacao_pkg.sv
// Shared types and helpers for the irrigation pump scheduler.
package irrigacao_pkg;

  localparam int unsigned LARG_TEMPO = 16;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ABRE     = 3'd1,
    IRRIGA   = 3'd2,
    FECHA    = 3'd3,
    DESCANSO = 3'd4
  } estado_t;

  function automatic int unsigned ms_para_ciclos(input int unsigned ms, input int unsigned clk_hz);
    return ms * (clk_hz / 1000);
  endfunction

endpackage

// File: rtl/gerador_tick_ms.sv
// Millisecond prescaler; restart realigns the ms phase to the current cycle.
module gerador_tick_ms #(
  parameter int unsigned CICLOS_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic reinicio,
  output logic tick_c
);

  localparam int unsigned CW   = (CICLOS_MS > 1) ? $clog2(CICLOS_MS) : 1;
  // Tick one cycle before each ms boundary so registered consumers settle on the boundary itself.
  localparam int unsigned FASE = (CICLOS_MS > 1) ? CICLOS_MS - 2 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || reinicio) begin
      cnt <= '0;
    end else if (cnt == CW'(CICLOS_MS - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_c = (cnt == CW'(FASE));

endmodule

// File: rtl/escalonador_bomba.sv
// Round-robin pump scheduler: grants one zone at a time and sequences valve, pump and rest intervals.
module escalonador_bomba
  import irrigacao_pkg::*;
#(
  parameter int unsigned N_ZONAS      = 4,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned ESTAB_MS     = 50,
  parameter int unsigned DESCANSO_MS  = 500,
  parameter int unsigned TEMPO_MAX_MS = 30000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_ZONAS-1:0]               req_valido,
  input  logic [LARG_TEMPO*N_ZONAS-1:0]    req_tempo_ms,
  input  logic                             alerta_nivel_baixo,
  output logic [N_ZONAS-1:0]               req_aceito,
  output logic [N_ZONAS-1:0]               valvula,
  output logic                             bomba_on,
  output logic [$clog2(N_ZONAS)-1:0]       zona_ativa,
  output logic [LARG_TEMPO-1:0]            tempo_restante_ms,
  output logic                             ocupado,
  output logic                             ciclo_fim,
  output logic                             ciclo_abortado
);

  localparam int unsigned ZW        = $clog2(N_ZONAS);
  localparam int unsigned CICLOS_MS = ms_para_ciclos(1, CLK_HZ);
  localparam logic [LARG_TEMPO-1:0] ESTAB = LARG_TEMPO'(ESTAB_MS);
  localparam logic [LARG_TEMPO-1:0] DESC  = LARG_TEMPO'(DESCANSO_MS);
  localparam logic [LARG_TEMPO-1:0] TMAX  = LARG_TEMPO'(TEMPO_MAX_MS);

  estado_t               estado, estado_prox;
  logic [ZW-1:0]         ptr, ptr_prox, zona_prox, vencedor, cand;
  logic [LARG_TEMPO-1:0] duracao, dur_prox, restante, restante_prox, tempo_lim;
  logic [LARG_TEMPO-1:0] tempos [N_ZONAS];
  logic [N_ZONAS-1:0]    aceito_c;
  logic                  achou, tick, reinicio, fim_prox, abort_prox;

  for (genvar g = 0; g < int'(N_ZONAS); g++) begin : g_tempo
    assign tempos[g] = req_tempo_ms[LARG_TEMPO*g +: LARG_TEMPO];
  end

  // Round-robin search starting after the last granted zone.
  always_comb begin
    achou    = 1'b0;
    vencedor = '0;
    cand     = '0;
    for (int k = 1; k <= int'(N_ZONAS); k++) begin
      cand = ZW'((int'(ptr) + k) % int'(N_ZONAS));
      if (!achou && req_valido[cand]) begin
        achou    = 1'b1;
        vencedor = cand;
      end
    end
    tempo_lim = (tempos[vencedor] > TMAX) ? TMAX : tempos[vencedor];
  end

  always_comb begin
    estado_prox   = estado;
    ptr_prox      = ptr;
    zona_prox     = zona_ativa;
    dur_prox      = duracao;
    restante_prox = restante;
    aceito_c      = '0;
    fim_prox      = 1'b0;
    abort_prox    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (!alerta_nivel_baixo && achou) begin
          aceito_c[vencedor] = 1'b1;
          ptr_prox           = vencedor;
          // A zero duration is consumed without running a cycle.
          if (tempo_lim != '0) begin
            estado_prox = ABRE;
            zona_prox   = vencedor;
            dur_prox    = tempo_lim;
          end
        end
      end
      ABRE: begin
        if (alerta_nivel_baixo) begin
          estado_prox = FECHA;
          abort_prox  = 1'b1;
        end else if (restante == '0) begin
          estado_prox = IRRIGA;
        end
      end
      IRRIGA: begin
        if (alerta_nivel_baixo) begin
          estado_prox = FECHA;
          abort_prox  = 1'b1;
        end else if (restante == '0) begin
          estado_prox = FECHA;
          fim_prox    = 1'b1;
        end
      end
      FECHA:    if (restante == '0) estado_prox = DESCANSO;
      DESCANSO: if (restante == '0) estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase

    // Interval counter reloads on every state entry and counts ms down to zero.
    if (estado_prox != estado) begin
      case (estado_prox)
        ABRE, FECHA: restante_prox = ESTAB;
        IRRIGA:      restante_prox = dur_prox;
        DESCANSO:    restante_prox = DESC;
        default:     restante_prox = '0;
      endcase
    end else if (tick && restante != '0) begin
      restante_prox = restante - LARG_TEMPO'(1);
    end
  end

  assign reinicio   = (estado_prox != estado);
  assign req_aceito = rst ? '0 : aceito_c;

  gerador_tick_ms #(.CICLOS_MS(CICLOS_MS)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .reinicio (reinicio),
    .tick_c   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado            <= OCIOSO;
      ptr               <= ZW'(N_ZONAS - 1);
      duracao           <= '0;
      restante          <= '0;
      valvula           <= '0;
      bomba_on          <= 1'b0;
      zona_ativa        <= '0;
      tempo_restante_ms <= '0;
      ocupado           <= 1'b0;
      ciclo_fim         <= 1'b0;
      ciclo_abortado    <= 1'b0;
    end else begin
      estado            <= estado_prox;
      ptr               <= ptr_prox;
      duracao           <= dur_prox;
      restante          <= restante_prox;
      valvula           <= (estado_prox inside {ABRE, IRRIGA, FECHA}) ? (N_ZONAS'(1) << zona_prox) : '0;
      bomba_on          <= (estado_prox == IRRIGA);
      zona_ativa        <= (estado_prox == OCIOSO) ? '0 : zona_prox;
      tempo_restante_ms <= (estado_prox == IRRIGA) ? restante_prox : '0;
      ocupado           <= (estado_prox != OCIOSO);
      ciclo_fim         <= fim_prox;
      ciclo_abortado    <= abort_prox;
    end
  end

endmodule

// File: tb/tb_escalonador_bomba.sv
// Directed self-checking bench for escalonador_bomba at 4 clock cycles per ms.
module tb_escalonador_bomba;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valido;
  logic [63:0] req_tempo_ms;
  logic        alerta;
  logic [3:0]  req_aceito;
  logic [3:0]  valvula;
  logic        bomba_on;
  logic [1:0]  zona_ativa;
  logic [15:0] tempo_restante_ms;
  logic        ocupado;
  logic        ciclo_fim;
  logic        ciclo_abortado;

  int n_cmp = 0;
  int n_err = 0;

  escalonador_bomba #(
    .N_ZONAS(4), .CLK_HZ(4000), .ESTAB_MS(2), .DESCANSO_MS(3), .TEMPO_MAX_MS(30000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valido         (req_valido),
    .req_tempo_ms       (req_tempo_ms),
    .alerta_nivel_baixo (alerta),
    .req_aceito         (req_aceito),
    .valvula            (valvula),
    .bomba_on           (bomba_on),
    .zona_ativa         (zona_ativa),
    .tempo_restante_ms  (tempo_restante_ms),
    .ocupado            (ocupado),
    .ciclo_fim          (ciclo_fim),
    .ciclo_abortado     (ciclo_abortado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pedir(input int z, input int t);
    req_valido[z] = 1'b1;
    req_tempo_ms[16*z +: 16] = 16'(t);
  endtask

  task automatic proximo();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valido = 4'b1111;
    for (int z = 0; z < 4; z++) req_tempo_ms[16*z +: 16] = 16'd5;
    for (int c = 0; c < 3; c++) begin
      proximo();
      n_cmp++;
      if ({valvula, bomba_on, zona_ativa, tempo_restante_ms, ocupado, ciclo_fim, ciclo_abortado} !== 26'd0) begin
        n_err++;
        $display("FAIL reset_saidas: got %0h expected 0",
                 {valvula, bomba_on, zona_ativa, tempo_restante_ms, ocupado, ciclo_fim, ciclo_abortado});
      end
      n_cmp++;
      if (req_aceito !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_aceito: got %b expected 0000", req_aceito);
      end
    end
    req_valido = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    logic [15:0] ult;
    proximo();
    pedir(2, 5);
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0100) begin n_err++; $display("FAIL single_aceito: got %b expected 0100", req_aceito); end
    proximo();
    req_valido = '0;
    n_cmp++;
    if ({valvula, zona_ativa, ocupado, bomba_on} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_abre: got v=%b z=%0d o=%b b=%b expected v=0100 z=2 o=1 b=0", valvula, zona_ativa, ocupado, bomba_on);
    end
    n = 0;
    while (valvula === 4'b0100 && bomba_on === 1'b0 && n < 100) begin n++; proximo(); end
    n_cmp++;
    if (n !== 8) begin n_err++; $display("FAIL single_abre_ciclos: got %0d expected 8", n); end
    n_cmp++;
    if (tempo_restante_ms !== 16'd5) begin n_err++; $display("FAIL single_restante_carga: got %0d expected 5", tempo_restante_ms); end
    n = 0;
    ult = 16'hffff;
    while (bomba_on === 1'b1 && n < 100) begin ult = tempo_restante_ms; n++; proximo(); end
    n_cmp++;
    if (n !== 20) begin n_err++; $display("FAIL single_bomba_ciclos: got %0d expected 20", n); end
    n_cmp++;
    if (ult !== 16'd0) begin n_err++; $display("FAIL single_restante_final: got %0d expected 0", ult); end
    n_cmp++;
    if ({ciclo_fim, ciclo_abortado, valvula} !== {1'b1, 1'b0, 4'b0100}) begin
      n_err++;
      $display("FAIL single_fim: got fim=%b ab=%b v=%b expected fim=1 ab=0 v=0100", ciclo_fim, ciclo_abortado, valvula);
    end
    n = 0;
    while (valvula === 4'b0100 && n < 100) begin n++; proximo(); end
    n_cmp++;
    if (n !== 8) begin n_err++; $display("FAIL single_fecha_ciclos: got %0d expected 8", n); end
    n = 0;
    while (ocupado === 1'b1 && n < 100) begin n++; proximo(); end
    n_cmp++;
    if (n !== 12) begin n_err++; $display("FAIL single_descanso_ciclos: got %0d expected 12", n); end
  endtask

  task automatic test_round_robin();
    logic [3:0] grants [4];
    logic [3:0] esperado [4];
    int g;
    int c;
    int n;
    esperado[0] = 4'b0001; esperado[1] = 4'b0010; esperado[2] = 4'b1000; esperado[3] = 4'b0001;
    for (int i = 0; i < 4; i++) grants[i] = 4'b0000;
    proximo();
    rst = 1'b1;
    proximo();
    rst = 1'b0;
    for (int z = 0; z < 4; z++) req_tempo_ms[16*z +: 16] = 16'd1;
    req_valido = 4'b1011;
    #1;
    g = 0;
    c = 0;
    while (g < 4 && c < 500) begin
      if (req_aceito !== 4'b0000) begin grants[g] = req_aceito; g++; end
      c++;
      if (g < 4) proximo();
    end
    proximo();
    req_valido = '0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (grants[i] !== esperado[i]) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b expected %b", i, grants[i], esperado[i]);
      end
    end
    n = 0;
    while (ocupado !== 1'b0 && n < 200) begin n++; proximo(); end
    n_cmp++;
    if (ocupado !== 1'b0) begin n_err++; $display("FAIL rr_drain: got ocupado=%b expected 0", ocupado); end
  endtask

  task automatic test_alert();
    int n;
    int aceitos;
    int fims;
    proximo();
    pedir(1, 10);
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0010) begin n_err++; $display("FAIL alert_aceito: got %b expected 0010", req_aceito); end
    proximo();
    req_valido = '0;
    n = 0;
    while (bomba_on !== 1'b1 && n < 50) begin n++; proximo(); end
    n_cmp++;
    if (bomba_on !== 1'b1) begin n_err++; $display("FAIL alert_irriga_inicio: got %b expected 1", bomba_on); end
    repeat (8) proximo();
    n_cmp++;
    if ({bomba_on, tempo_restante_ms} !== {1'b1, 16'd8}) begin
      n_err++;
      $display("FAIL alert_ms2: got b=%b t=%0d expected b=1 t=8", bomba_on, tempo_restante_ms);
    end
    alerta = 1'b1;
    proximo();
    n_cmp++;
    if ({bomba_on, ciclo_abortado, ciclo_fim, valvula} !== {1'b0, 1'b1, 1'b0, 4'b0010}) begin
      n_err++;
      $display("FAIL alert_aborto: got b=%b ab=%b fim=%b v=%b expected b=0 ab=1 fim=0 v=0010",
               bomba_on, ciclo_abortado, ciclo_fim, valvula);
    end
    pedir(2, 3);
    aceitos = 0;
    fims = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_aceito !== 4'b0000) aceitos++;
      if (ciclo_fim !== 1'b0) fims++;
      proximo();
    end
    n_cmp++;
    if ({aceitos, fims} !== {32'd0, 32'd0} || ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL alert_bloqueio: got aceitos=%0d fims=%0d ocupado=%b expected 0 0 0", aceitos, fims, ocupado);
    end
    alerta = 1'b0;
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0100) begin n_err++; $display("FAIL alert_liberado: got %b expected 0100", req_aceito); end
    proximo();
    req_valido = '0;
    n = 0;
    while (ocupado !== 1'b0 && n < 200) begin n++; proximo(); end
    n_cmp++;
    if (ocupado !== 1'b0) begin n_err++; $display("FAIL alert_drain: got ocupado=%b expected 0", ocupado); end
  endtask

  task automatic test_boundary();
    int n;
    int ruins;
    proximo();
    pedir(3, 0);
    #1;
    n_cmp++;
    if (req_aceito !== 4'b1000) begin n_err++; $display("FAIL zero_aceito: got %b expected 1000", req_aceito); end
    proximo();
    req_valido = '0;
    ruins = 0;
    for (int c = 0; c < 4; c++) begin
      if (valvula !== 4'b0000 || ocupado !== 1'b0) ruins++;
      proximo();
    end
    n_cmp++;
    if (ruins !== 0) begin n_err++; $display("FAIL zero_ocioso: got %0d busy cycles expected 0", ruins); end
    pedir(0, 40000);
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0001) begin n_err++; $display("FAIL max_aceito: got %b expected 0001", req_aceito); end
    proximo();
    req_valido = '0;
    n = 0;
    while (bomba_on !== 1'b1 && n < 50) begin n++; proximo(); end
    n_cmp++;
    if (tempo_restante_ms !== 16'd30000) begin
      n_err++;
      $display("FAIL max_clamp: got %0d expected 30000", tempo_restante_ms);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (5) proximo();
    n_cmp++;
    if (bomba_on !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got bomba=%b expected 1", bomba_on); end
    rst = 1'b1;
    pedir(0, 2);
    pedir(1, 2);
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0000) begin n_err++; $display("FAIL rst_mid_aceito: got %b expected 0000", req_aceito); end
    proximo();
    n_cmp++;
    if ({bomba_on, valvula, ocupado, tempo_restante_ms, ciclo_abortado, ciclo_fim} !== 24'd0) begin
      n_err++;
      $display("FAIL rst_mid_saidas: got b=%b v=%b o=%b t=%0d ab=%b fim=%b expected all 0",
               bomba_on, valvula, ocupado, tempo_restante_ms, ciclo_abortado, ciclo_fim);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_aceito !== 4'b0001) begin n_err++; $display("FAIL rst_mid_ponteiro: got %b expected 0001", req_aceito); end
    proximo();
    req_valido = '0;
    n = 0;
    while (ocupado !== 1'b0 && n < 200) begin n++; proximo(); end
    n_cmp++;
    if (ocupado !== 1'b0) begin n_err++; $display("FAIL rst_mid_drain: got ocupado=%b expected 0", ocupado); end
  endtask

  initial begin
    rst = 1'b1;
    req_valido = '0;
    req_tempo_ms = '0;
    alerta = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_alert();
    test_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
